imem_responder: RTL

Responder end of the instruction-fetch request/grant protocol: accepts one fetch request at a time from the fetch unit, grants it, and returns the addressed 32-bit instruction after a fixed, parameterised latency. It models slow instruction DRAM so the fetch stage's grant and valid handling is exercised. It replaces the zero-wait instruction memory behind the IF stage, with the same mem_en/request/address inputs and valid/data outputs. A flush input cancels in-flight fetches on a PC redirect, and a preload port initialises the program image.

---
 rtl/imem_responder_pkg.sv | 23 ++
 rtl/imem_array.sv | 35 +++
 rtl/imem_responder.sv | 117 +++++++++++
 3 files changed

// File: rtl/imem_responder_pkg.sv
// Shared types and constants for the instruction-memory responder.
//   imem_state_t   : responder FSM states
//   NOP_INSTR      : word returned for a faulting fetch
//   fetch_addr_err : misaligned / out-of-range check for a byte address
package imem_responder_pkg;

  typedef enum logic [1:0] {
    IMEM_IDLE,
    IMEM_BUSY,
    IMEM_RESP
  } imem_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // 33-bit compare so DEPTH_WORDS*4 cannot wrap for large depths.
  function automatic logic fetch_addr_err(input logic [31:0] addr,
                                          input int unsigned depth_words);
    logic [32:0] limit;
    limit = 33'(depth_words) << 2;
    return (addr[1:0] != 2'b00) || ({1'b0, addr} >= limit);
  endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction storage: DEPTH_WORDS x 32, synchronous write, registered read.
//   clock, reset     : clock; synchronous active-high reset (read register only)
//   load_we_ip/...   : preload write port, always accepted
//   rd_en_ip/addr    : read enable and word index
//   rd_data_op       : registered read data (old data on same-edge write)
module imem_array #(
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           load_we_ip,
  input  logic [$clog2(DEPTH_WORDS)-1:0] load_addr_ip,
  input  logic [31:0]                    load_data_ip,
  input  logic                           rd_en_ip,
  input  logic [$clog2(DEPTH_WORDS)-1:0] rd_addr_ip,
  output logic [31:0]                    rd_data_op
);

  logic [31:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clock) begin
    if (load_we_ip) begin
      mem_q[load_addr_ip] <= load_data_ip;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_data_op <= '0;
    end else if (rd_en_ip) begin
      rd_data_op <= mem_q[rd_addr_ip];
    end
  end

endmodule

// File: rtl/imem_responder.sv
// Fixed-latency instruction-fetch responder (request/grant, one fetch in flight).
//   clock, reset          : clock; synchronous active-high reset
//   mem_en                : enables acceptance of new requests
//   instr_req_ip/addr_ip  : fetch request and byte address
//   flush_ip              : cancels a fetch still in BUSY
//   load_*_ip             : preload port into the storage array
//   instr_gnt_op          : one-cycle grant, cycle after acceptance
//   instr_valid_op        : one-cycle response, LATENCY cycles after acceptance
//   instr_data_op/err_op  : response word / fault flag, qualified by valid
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 3
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           mem_en,
  input  logic                           instr_req_ip,
  input  logic [31:0]                    instr_addr_ip,
  input  logic                           flush_ip,
  input  logic                           load_we_ip,
  input  logic [$clog2(DEPTH_WORDS)-1:0] load_addr_ip,
  input  logic [31:0]                    load_data_ip,
  output logic                           instr_gnt_op,
  output logic                           instr_valid_op,
  output logic [31:0]                    instr_data_op,
  output logic                           instr_err_op
);

  localparam int unsigned AW     = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

  imem_state_t state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        gnt_q, valid_q, err_q;
  logic        accept, rd_en, fetch_err;
  logic [31:0] fetch_addr, rd_data;

  // With LATENCY=1 the array is read on the acceptance edge itself, so the
  // address comes straight from the request bus rather than the latch.
  assign fetch_addr = (LATENCY == 1) ? instr_addr_ip : addr_q;
  assign fetch_err  = fetch_addr_err(fetch_addr, DEPTH_WORDS);

  // RESP behaves like IDLE for acceptance, giving back-to-back fetches.
  assign accept = (state_q != IMEM_BUSY) && mem_en && instr_req_ip;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rd_en   = 1'b0;
    case (state_q)
      IMEM_BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (flush_ip) begin
          state_d = IMEM_IDLE;
        end else if (cnt_q == 4'd1) begin
          state_d = IMEM_RESP;
          rd_en   = 1'b1;
        end
      end
      default: begin
        state_d = IMEM_IDLE;
        if (accept) begin
          addr_d = instr_addr_ip;
          cnt_d  = LAT_M1;
          if (LATENCY == 1) begin
            state_d = IMEM_RESP;
            rd_en   = 1'b1;
          end else begin
            state_d = IMEM_BUSY;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IMEM_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      gnt_q   <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      gnt_q   <= accept;
      valid_q <= rd_en;
      err_q   <= rd_en & fetch_err;
    end
  end

  // Faulting fetches skip the array; their word is replaced by a NOP.
  imem_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clock        (clock),
    .reset        (reset),
    .load_we_ip   (load_we_ip),
    .load_addr_ip (load_addr_ip),
    .load_data_ip (load_data_ip),
    .rd_en_ip     (rd_en & ~fetch_err),
    .rd_addr_ip   (fetch_addr[AW+1:2]),
    .rd_data_op   (rd_data)
  );

  assign instr_gnt_op   = gnt_q;
  assign instr_valid_op = valid_q;
  assign instr_err_op   = err_q;
  assign instr_data_op  = valid_q ? (err_q ? NOP_INSTR : rd_data) : 32'h0;

endmodule
